addsub_sat_pipe: RTL
====================

// Module: addsub_sat_pipe
// PURPOSE
// Multi-lane pipelined signed fixed-point add/subtract unit with saturation and valid/ready flow control.
// Replaces the single combinational a-b subtractor in the neural-network datapath: error terms, bias updates and
// weight deltas for all LANES neurons of one layer are processed in one transaction.
// Op is selected per transaction; results clamp to the DWIDTH signed range instead of wrapping.
// PARAMETERS
// DWIDTH   16  operand/result width, two's-complement signed
// LANES    4   independent lanes per transaction
// SAT_EN   1   1: clamp on overflow; 0: wrap modulo 2^DWIDTH, flags still report overflow
// PORTS
// clk          in   1              rising-edge clock
// rst          in   1              synchronous reset, active high
// in_valid     in   1              transaction present on a/b/op
// in_ready     out  1              unit accepts transaction this cycle
// op           in   2              00 SUB a-b, 01 ADD a+b, 10 RSUB b-a, 11 ABSDIFF |a-b|
// a            in   LANES*DWIDTH   lane i = a[i*DWIDTH +: DWIDTH], signed
// b            in   LANES*DWIDTH   same packing as a
// out_valid    out  1              result valid
// out_ready    in   1              consumer accepts result
// c            out  LANES*DWIDTH   results, same packing
// ovf          out  LANES          per-lane overflow of the result currently on c
// ovf_sticky   out  LANES          per-lane sticky overflow since last clear
// clr_ovf      in   1              synchronous clear of ovf_sticky
// BEHAVIOUR
// - Reset: in_ready=0 during rst, out_valid=0, c=0, ovf=0, ovf_sticky=0; both pipeline stages empty.
// - Transfer on in_valid&in_ready (input), out_valid&out_ready (output). Data ignored when valid low.
// - Two register stages: S1 holds DWIDTH+1-bit raw result + op; S2 holds saturated c and ovf.
//   Latency 2 cycles input-accept to out_valid with out_ready held high; throughput 1/cycle.
// - Stage load enable: stage loads when empty or its contents leave this cycle. in_ready = ~S1full | S1 moves;
//   combinational out_ready->in_ready path is permitted. Stalled stages hold data bit-exact.
// - out_valid/c/ovf must not change while out_valid=1 and out_ready=0.
// - Arithmetic: sign-extend a,b to DWIDTH+1, compute a-b / a+b / b-a / |a-b| (abs of the DWIDTH+1 diff).
//   Overflow when raw result outside [-2^(DWIDTH-1), 2^(DWIDTH-1)-1]; SAT_EN=1 clamps to that bound.
//   ABSDIFF result is always >=0; only positive clamp possible.
// - ovf_sticky[i] sets when a result with ovf[i]=1 is loaded into S2. clr_ovf and set same cycle: set wins.
// - Reset mid-operation discards both stages; no partial result is emitted after rst deasserts.
// - Lanes share op and handshake; no lane-to-lane interaction.
// STRUCTURE
// - Shared package addsub_pkg: op encodings (OP_SUB, OP_ADD, OP_RSUB, OP_ABSDIFF), function sat_max/sat_min(DWIDTH).
// - Sub-module addsub_lane: combinational per-lane op + overflow detect + clamp, instantiated LANES times
//   via generate; top holds the two pipeline stages, handshake and sticky flags.
// TESTING (DWIDTH=16, LANES=4, SAT_EN=1 unless noted)
// 1 SUB a={100,-5,0,32767} b={30,5,0,-1}, out_ready=1 -> after 2 cycles c={70,-10,0,32767}, ovf=0001(lane3).
// 2 ADD lane0 a=-32768 b=-1 -> c=-32768, ovf[0]=1, ovf_sticky[0]=1; SAT_EN=0 -> c=32767, ovf[0]=1.
// 3 ABSDIFF a=-32768 b=32767 -> c=32767, ovf=1; RSUB a=3 b=10 -> c=7, ovf=0.
// 4 Stream 8 transactions back-to-back, out_ready low cycles 3-6 -> c held stable, in_ready low once S1,S2 full,
//   all 8 results emitted in order, none lost or duplicated.
// 5 clr_ovf asserted same cycle as an overflowing result enters S2 -> ovf_sticky stays 1; next clr alone -> 0.
// 6 rst asserted with both stages full -> next cycle out_valid=0, c=0, ovf_sticky=0; no stale output after release.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the saturating add/subtract pipeline: op encodings and
// the signed clamp bounds for a given result width.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_SUB     = 2'b00,
    OP_ADD     = 2'b01,
    OP_RSUB    = 2'b10,
    OP_ABSDIFF = 2'b11
  } op_e;

  function automatic int sat_max(int dwidth);
    return (1 << (dwidth - 1)) - 1;
  endfunction

  function automatic int sat_min(int dwidth);
    return -(1 << (dwidth - 1));
  endfunction

endpackage

// File: rtl/addsub_lane.sv
// One lane of the add/subtract unit: raw DWIDTH+1-bit arithmetic feeding stage 1,
// and abs/overflow/clamp logic operating on the stage-1 registered result.
module addsub_lane import addsub_pkg::*; #(
  parameter int DWIDTH = 16,
  parameter bit SAT_EN = 1'b1
) (
  input  logic [1:0]        op,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic [DWIDTH:0]   raw,
  input  logic [1:0]        op_s1,
  input  logic [DWIDTH:0]   raw_s1,
  output logic [DWIDTH-1:0] res,
  output logic              ovf
);

  localparam logic signed [DWIDTH:0] MAX_V = (DWIDTH + 1)'(sat_max(DWIDTH));
  localparam logic signed [DWIDTH:0] MIN_V = (DWIDTH + 1)'(sat_min(DWIDTH));

  logic signed [DWIDTH:0] ax;
  logic signed [DWIDTH:0] bx;
  logic signed [DWIDTH:0] mag;

  assign ax = {a[DWIDTH-1], a};
  assign bx = {b[DWIDTH-1], b};

  // ABSDIFF leaves stage 1 as a plain a-b; the magnitude is taken after the register.
  always_comb begin
    case (op)
      OP_ADD:  raw = ax + bx;
      OP_RSUB: raw = bx - ax;
      default: raw = ax - bx;
    endcase
  end

  // |a-b| of two DWIDTH-bit values is at most 2^DWIDTH-1, so it still fits DWIDTH+1 bits.
  always_comb begin
    mag = raw_s1;
    if (op_s1 == OP_ABSDIFF && raw_s1[DWIDTH]) begin
      mag = -raw_s1;
    end
    ovf = (mag > MAX_V) || (mag < MIN_V);
    res = mag[DWIDTH-1:0];
    if (SAT_EN) begin
      if (mag > MAX_V) begin
        res = MAX_V[DWIDTH-1:0];
      end else if (mag < MIN_V) begin
        res = MIN_V[DWIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/addsub_sat_pipe.sv
// Multi-lane pipelined signed add/subtract with saturation: stage 1 holds raw sums,
// stage 2 the clamped results; valid/ready handshake on both sides, sticky overflow flags.
module addsub_sat_pipe import addsub_pkg::*; #(
  parameter int DWIDTH = 16,
  parameter int LANES  = 4,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              op,
  input  logic [LANES*DWIDTH-1:0] a,
  input  logic [LANES*DWIDTH-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DWIDTH-1:0] c,
  output logic [LANES-1:0]        ovf,
  output logic [LANES-1:0]        ovf_sticky,
  input  logic                    clr_ovf
);

  localparam int RW = DWIDTH + 1;

  logic                    s1_full_reg;
  logic [1:0]              s1_op_reg;
  logic [LANES*RW-1:0]     s1_raw_reg;
  logic                    s2_full_reg;
  logic [LANES*DWIDTH-1:0] c_reg;
  logic [LANES-1:0]        ovf_reg;
  logic [LANES-1:0]        sticky_reg;

  logic [LANES*RW-1:0]     lane_raw;
  logic [LANES*DWIDTH-1:0] lane_res;
  logic [LANES-1:0]        lane_ovf;

  logic s2_load;
  logic s1_move;
  logic s1_load;
  logic in_fire;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      addsub_lane #(
        .DWIDTH(DWIDTH),
        .SAT_EN(SAT_EN)
      ) u_lane (
        .op    (op),
        .a     (a[gi*DWIDTH +: DWIDTH]),
        .b     (b[gi*DWIDTH +: DWIDTH]),
        .raw   (lane_raw[gi*RW +: RW]),
        .op_s1 (s1_op_reg),
        .raw_s1(s1_raw_reg[gi*RW +: RW]),
        .res   (lane_res[gi*DWIDTH +: DWIDTH]),
        .ovf   (lane_ovf[gi])
      );
    end
  endgenerate

  // A stage may load when it is empty or its current contents leave this cycle.
  assign s2_load  = ~s2_full_reg | out_ready;
  assign s1_move  = s1_full_reg & s2_load;
  assign s1_load  = ~s1_full_reg | s1_move;
  assign in_ready = ~rst & s1_load;
  assign in_fire  = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_full_reg <= 1'b0;
      s1_op_reg   <= '0;
      s1_raw_reg  <= '0;
      s2_full_reg <= 1'b0;
      c_reg       <= '0;
      ovf_reg     <= '0;
      sticky_reg  <= '0;
    end else begin
      if (s1_load) begin
        s1_full_reg <= in_fire;
        if (in_fire) begin
          s1_op_reg  <= op;
          s1_raw_reg <= lane_raw;
        end
      end
      if (s2_load) begin
        s2_full_reg <= s1_full_reg;
        if (s1_full_reg) begin
          c_reg   <= lane_res;
          ovf_reg <= lane_ovf;
        end
      end
      // A new overflow arriving in the same cycle as a clear takes precedence.
      sticky_reg <= (clr_ovf ? '0 : sticky_reg) | (s1_move ? lane_ovf : '0);
    end
  end

  assign out_valid  = s2_full_reg;
  assign c          = c_reg;
  assign ovf        = ovf_reg;
  assign ovf_sticky = sticky_reg;

endmodule
